// File: rtl/ex_idiv_unit_pkg.sv
// Shared encodings for the EX-stage iterative divider: RV32M funct3 values and FSM states.
package ex_idiv_unit_pkg;

  localparam int unsigned XLEN_DEFAULT = 32;

  typedef enum logic [2:0] {
    F3_DIV  = 3'b100,
    F3_DIVU = 3'b101,
    F3_REM  = 3'b110,
    F3_REMU = 3'b111
  } funct3_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  function automatic logic f3_is_signed(input logic [2:0] f3);
    return (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

  function automatic logic f3_is_rem(input logic [2:0] f3);
    return (f3 == F3_REM) || (f3 == F3_REMU);
  endfunction

endpackage

// File: rtl/ex_idiv_unit_idiv_step.sv
// One restoring-division iteration: shift {rem,quo} left, trial-subtract the divisor,
// keep the difference and set the quotient bit when it does not go negative.
module ex_idiv_unit_idiv_step #(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] rem_i,
  input  logic [XLEN-1:0] quo_i,
  input  logic [XLEN-1:0] dvs_i,
  output logic [XLEN-1:0] rem_o,
  output logic [XLEN-1:0] quo_o
);

  logic [XLEN:0] rem_sh;
  logic [XLEN:0] trial;

  always_comb begin
    rem_sh = {rem_i, quo_i[XLEN-1]};
    trial  = rem_sh - {1'b0, dvs_i};
    if (trial[XLEN]) begin
      rem_o = rem_sh[XLEN-1:0];
      quo_o = {quo_i[XLEN-2:0], 1'b0};
    end else begin
      rem_o = trial[XLEN-1:0];
      quo_o = {quo_i[XLEN-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/ex_idiv_unit.sv
// EX-stage radix-2 divider for DIV/DIVU/REM/REMU: stalls the front end while iterating
// on operand magnitudes, then emits a single done_o pulse with the signed-corrected result.
module ex_idiv_unit
  import ex_idiv_unit_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEFAULT
) (
  input  logic            CLK,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic            flush_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic [4:0]      rd_i,
  output logic            stall_o,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o,
  output logic [4:0]      rd_o
);

  localparam int unsigned CNT_W = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_e state_q, state_d;

  logic [XLEN-1:0]  quo_q, quo_d, rem_q, rem_d, dvs_q, dvs_d;
  logic [XLEN-1:0]  result_q, result_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0]       rd_lat_q, rd_lat_d, rd_out_q, rd_out_d;
  logic             is_rem_q, is_rem_d, qneg_q, qneg_d, rneg_q, rneg_d;

  logic            is_sgn, a_neg, b_neg, div_zero, ovf;
  logic [XLEN-1:0] a_mag, b_mag, step_rem, step_quo, q_fix, r_fix;

  ex_idiv_unit_idiv_step #(.XLEN(XLEN)) u_step (
    .rem_i (rem_q),
    .quo_i (quo_q),
    .dvs_i (dvs_q),
    .rem_o (step_rem),
    .quo_o (step_quo)
  );

  // Operand classification and magnitude/sign-fixup arithmetic
  always_comb begin
    is_sgn   = f3_is_signed(funct3_i);
    a_neg    = is_sgn & rs1_i[XLEN-1];
    b_neg    = is_sgn & rs2_i[XLEN-1];
    a_mag    = a_neg ? XLEN'(-rs1_i) : rs1_i;
    b_mag    = b_neg ? XLEN'(-rs2_i) : rs2_i;
    div_zero = (rs2_i == '0);
    ovf      = is_sgn && (rs1_i == MIN_NEG) && (rs2_i == '1);
    q_fix    = qneg_q ? XLEN'(-quo_q) : quo_q;
    r_fix    = rneg_q ? XLEN'(-rem_q) : rem_q;
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: if (start_i) state_d = (div_zero || ovf) ? S_DONE : S_CALC;
        S_CALC: if (cnt_q == CNT_W'(XLEN-1)) state_d = S_FIX;
        S_FIX:  state_d = S_DONE;
        S_DONE: state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Stall drops in DONE so the pipeline advances while the result is captured
  always_comb begin
    stall_o = !flush_i && (((state_q == S_IDLE) && start_i) ||
                           (state_q == S_CALC) || (state_q == S_FIX));
    busy_o  = (state_q != S_IDLE);
    done_o  = (state_q == S_DONE);
  end

  always_comb begin
    quo_d    = quo_q;
    rem_d    = rem_q;
    dvs_d    = dvs_q;
    cnt_d    = cnt_q;
    is_rem_d = is_rem_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    rd_lat_d = rd_lat_q;
    result_d = result_q;
    rd_out_d = rd_out_q;
    if (!flush_i) begin
      case (state_q)
        S_IDLE: if (start_i) begin
          is_rem_d = f3_is_rem(funct3_i);
          qneg_d   = a_neg ^ b_neg;
          rneg_d   = a_neg;
          rd_lat_d = rd_i;
          quo_d    = a_mag;
          rem_d    = '0;
          dvs_d    = b_mag;
          cnt_d    = '0;
          // Special cases resolve immediately and skip the iteration
          if (div_zero) begin
            result_d = f3_is_rem(funct3_i) ? rs1_i : '1;
            rd_out_d = rd_i;
          end else if (ovf) begin
            result_d = f3_is_rem(funct3_i) ? '0 : MIN_NEG;
            rd_out_d = rd_i;
          end
        end
        S_CALC: begin
          rem_d = step_rem;
          quo_d = step_quo;
          cnt_d = cnt_q + CNT_W'(1);
        end
        S_FIX: begin
          result_d = is_rem_q ? r_fix : q_fix;
          rd_out_d = rd_lat_q;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      quo_q    <= '0;
      rem_q    <= '0;
      dvs_q    <= '0;
      cnt_q    <= '0;
      is_rem_q <= 1'b0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      rd_lat_q <= '0;
      result_q <= '0;
      rd_out_q <= '0;
    end else begin
      quo_q    <= quo_d;
      rem_q    <= rem_d;
      dvs_q    <= dvs_d;
      cnt_q    <= cnt_d;
      is_rem_q <= is_rem_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      rd_lat_q <= rd_lat_d;
      result_q <= result_d;
      rd_out_q <= rd_out_d;
    end
  end

  assign result_o = result_q;
  assign rd_o     = rd_out_q;

endmodule

// File: tb/tb_ex_idiv_unit.sv
// Directed and randomized checks of ex_idiv_unit: results, rd tagging, latency, stall,
// flush abort and mid-operation reset.
module tb_ex_idiv_unit;

  localparam logic [2:0] DIV  = 3'b100;
  localparam logic [2:0] DIVU = 3'b101;
  localparam logic [2:0] REM  = 3'b110;
  localparam logic [2:0] REMU = 3'b111;

  logic        CLK = 1'b0;
  logic        rst_n;
  logic        start_i, flush_i;
  logic [2:0]  funct3_i;
  logic [31:0] rs1_i, rs2_i;
  logic [4:0]  rd_i;
  logic        stall_o, busy_o, done_o;
  logic [31:0] result_o;
  logic [4:0]  rd_o;

  always #5 CLK = ~CLK;

  ex_idiv_unit #(.XLEN(32)) dut (
    .CLK      (CLK),
    .rst_n    (rst_n),
    .start_i  (start_i),
    .flush_i  (flush_i),
    .funct3_i (funct3_i),
    .rs1_i    (rs1_i),
    .rs2_i    (rs2_i),
    .rd_i     (rd_i),
    .stall_o  (stall_o),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .result_o (result_o),
    .rd_o     (rd_o)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a,
                                            input logic [31:0] b);
    int sa, sb;
    logic [31:0] r;
    sa = a;
    sb = b;
    case (f3)
      DIV:  if (b == 0) r = 32'hFFFF_FFFF;
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h8000_0000;
            else r = 32'(sa / sb);
      REM:  if (b == 0) r = a;
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h0;
            else r = 32'(sa % sb);
      DIVU: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  // Issue one op and hold start_i until the done cycle; reports result, rd, latency, stall shape
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, output logic [31:0] res, output logic [4:0] rdo,
                        output int lat, output logic stall_ok);
    res = '0;
    rdo = '0;
    lat = -1;
    @(posedge CLK); #1;
    start_i = 1'b1; funct3_i = f3; rs1_i = a; rs2_i = b; rd_i = rd;
    #1;
    stall_ok = (stall_o === 1'b1);
    for (int c = 1; c <= 40; c++) begin
      @(posedge CLK); #1;
      if (done_o === 1'b1) begin
        lat = c;
        res = result_o;
        rdo = rd_o;
        if (stall_o !== 1'b0) stall_ok = 1'b0;
        break;
      end
      if (stall_o !== 1'b1) stall_ok = 1'b0;
    end
  endtask

  task automatic idle_gap(input string nm);
    @(posedge CLK); #1;
    start_i = 1'b0;
    chk({nm, "_single_done"}, 32'(done_o), 32'd0);
    chk({nm, "_idle"}, 32'(busy_o), 32'd0);
  endtask

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t        vt[16];
  logic [31:0] res;
  logic [4:0]  rdo;
  int          lat;
  logic        sok;
  int          ndone;

  initial begin
    vt[0]  = '{DIVU, 32'd100,        32'd7,          5'd1,  32'd14,         34};
    vt[1]  = '{REMU, 32'd100,        32'd7,          5'd2,  32'd2,          34};
    vt[2]  = '{DIV,  32'hFFFF_FFF9,  32'd2,          5'd3,  32'hFFFF_FFFD,  34};
    vt[3]  = '{REM,  32'hFFFF_FFF9,  32'd2,          5'd4,  32'hFFFF_FFFF,  34};
    vt[4]  = '{DIV,  32'd7,          32'hFFFF_FFFE,  5'd5,  32'hFFFF_FFFD,  34};
    vt[5]  = '{REM,  32'd7,          32'hFFFF_FFFE,  5'd6,  32'd1,          34};
    vt[6]  = '{DIV,  32'd5,          32'd0,          5'd7,  32'hFFFF_FFFF,  1};
    vt[7]  = '{REMU, 32'd5,          32'd0,          5'd8,  32'd5,          1};
    vt[8]  = '{DIV,  32'h8000_0000,  32'hFFFF_FFFF,  5'd9,  32'h8000_0000,  1};
    vt[9]  = '{REM,  32'h8000_0000,  32'hFFFF_FFFF,  5'd10, 32'd0,          1};
    vt[10] = '{DIVU, 32'h8000_0000,  32'hFFFF_FFFF,  5'd11, 32'd0,          34};
    vt[11] = '{DIVU, 32'hFFFF_FFFF,  32'd1,          5'd12, 32'hFFFF_FFFF,  34};
    vt[12] = '{REM,  32'hFFFF_FFF8,  32'hFFFF_FFFD,  5'd13, 32'hFFFF_FFFE,  34};
    vt[13] = '{DIV,  32'hFFFF_FFF8,  32'hFFFF_FFFD,  5'd14, 32'd2,          34};
    vt[14] = '{REMU, 32'hFFFF_FFFF,  32'h10,         5'd15, 32'hF,          34};
    vt[15] = '{REM,  32'd9,          32'd0,          5'd31, 32'd9,          1};

    rst_n = 1'b0; start_i = 1'b0; flush_i = 1'b0;
    funct3_i = DIVU; rs1_i = '0; rs2_i = '0; rd_i = '0;

    #12;
    chk("rst_busy",   32'(busy_o), 32'd0);
    chk("rst_done",   32'(done_o), 32'd0);
    chk("rst_result", result_o,    32'd0);
    chk("rst_rd",     32'(rd_o),   32'd0);
    chk("rst_stall0", 32'(stall_o), 32'd0);
    start_i = 1'b1; #1;
    chk("rst_stall1", 32'(stall_o), 32'd1);
    start_i = 1'b0;
    @(negedge CLK); rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      run_op(vt[i].f3, vt[i].a, vt[i].b, vt[i].rd, res, rdo, lat, sok);
      chk($sformatf("vec%0d_result", i), res, vt[i].exp);
      chk($sformatf("vec%0d_rd", i), 32'(rdo), 32'(vt[i].rd));
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(vt[i].lat));
      chk($sformatf("vec%0d_stall", i), 32'(sok), 32'd1);
      idle_gap($sformatf("vec%0d", i));
    end

    // Back-to-back: new op issued in the cycle right after DONE
    run_op(DIVU, 32'd1000, 32'd3, 5'd20, res, rdo, lat, sok);
    chk("b2b_first", res, 32'd333);
    run_op(DIV, 32'hFFFF_FF9C, 32'd9, 5'd21, res, rdo, lat, sok);
    chk("b2b_second", res, 32'hFFFF_FFF5);
    chk("b2b_rd", 32'(rdo), 32'd21);
    chk("b2b_latency", 32'(lat), 32'd34);
    idle_gap("b2b");

    // Flush at cycle 10 of a DIVU
    @(posedge CLK); #1;
    start_i = 1'b1; funct3_i = DIVU; rs1_i = 32'd12345; rs2_i = 32'd17; rd_i = 5'd22;
    for (int c = 1; c <= 10; c++) begin @(posedge CLK); #1; end
    flush_i = 1'b1; #1;
    chk("flush_stall_comb", 32'(stall_o), 32'd0);
    @(posedge CLK); #1;
    flush_i = 1'b0; start_i = 1'b0;
    chk("flush_busy", 32'(busy_o), 32'd0);
    chk("flush_stall", 32'(stall_o), 32'd0);
    ndone = 0;
    for (int c = 0; c < 40; c++) begin @(posedge CLK); #1; if (done_o) ndone++; end
    chk("flush_no_done", 32'(ndone), 32'd0);

    // Asynchronous reset mid-operation
    @(posedge CLK); #1;
    start_i = 1'b1; funct3_i = REM; rs1_i = 32'd999; rs2_i = 32'd10; rd_i = 5'd23;
    for (int c = 1; c <= 5; c++) begin @(posedge CLK); #1; end
    chk("prerst_busy", 32'(busy_o), 32'd1);
    rst_n = 1'b0; #1;
    chk("midrst_busy", 32'(busy_o), 32'd0);
    chk("midrst_result", result_o, 32'd0);
    start_i = 1'b0;
    @(negedge CLK); rst_n = 1'b1;
    ndone = 0;
    for (int c = 0; c < 40; c++) begin @(posedge CLK); #1; if (done_o) ndone++; end
    chk("midrst_no_done", 32'(ndone), 32'd0);

    // Randomized signed/unsigned pairs against the reference model
    for (int i = 0; i < 400; i++) begin
      logic [2:0]  f3;
      logic [31:0] a, b;
      logic [4:0]  rd;
      f3 = {1'b1, 2'($urandom_range(3, 0))};
      a  = $urandom >> $urandom_range(31, 0);
      b  = $urandom >> $urandom_range(31, 0);
      if ($urandom_range(1, 0) == 1) a = ~a;
      if ($urandom_range(3, 0) == 0) b = ~b;
      if (i % 50 == 7) b = '0;
      if (i % 50 == 13) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      rd = 5'($urandom);
      run_op(f3, a, b, rd, res, rdo, lat, sok);
      chk($sformatf("rnd%0d_f3=%b_a=%08h_b=%08h_result", i, f3, a, b), res, ref_model(f3, a, b));
      chk($sformatf("rnd%0d_rd", i), 32'(rdo), 32'(rd));
      chk($sformatf("rnd%0d_stall", i), 32'(sok), 32'd1);
    end
    idle_gap("rnd_end");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
